lcd_scan_driver: RTL and testbench
==================================

Name: lcd_scan_driver

Overview:
- Parametrised N-digit, 4-COM multiplexed segment-LCD driver.
- Takes per-digit 8-bit character codes plus decimal-point and blink controls.
- Round-robin sequencer decodes each code through an internal registered character map into per-digit segment latches.
- Generates DC-balanced COM/SEG waveforms (1/4 duty, PWM mid-level) and tri-states all pad outputs in standby. Sits between application logic and the LCD pads.

Parameters:
- NUM_DIGITS, 4: number of digits; 1..16.
- CLK_DIV_W, 2: prescaler width; tick every 2^CLK_DIV_W clk_in cycles.
- PWM_BIT, 2: lcd_cnt bit used as PWM mid-level.
- FRAME_BIT, 12: lcd_cnt LSB of 3-bit frame phase; FRAME_BIT > PWM_BIT.
- BLINK_BIT, 20: lcd_cnt bit used as blink phase; BLINK_BIT > FRAME_BIT+2.

Ports:
- clk_in  in  1  system clock
- rst  in  1  asynchronous active-high reset
- stdby  in  1  1 = halt tick and tri-state all LCD outputs
- char_codes  in  8*NUM_DIGITS  digit d code at [8d+7:8d]
- dp  in  NUM_DIGITS  decimal point per digit
- blink_en  in  NUM_DIGITS  1 = digit blanked while blink phase is 0
- lcd_com  out  4  COM pads, Z in standby
- lcd_seg  out  2*NUM_DIGITS  SEG pads, Z in standby
- refresh_done  out  1  one-clk_in pulse when all digits have been re-latched

Behaviour:
- Reset (async, rst=1): prescaler=0, lcd_cnt=0, digit index=0, state=S_ADDR, all segment latches=0, lcd_com/lcd_seg registers=0, refresh_done=0.
- tick = (prescaler all-ones) & ~stdby. Prescaler increments only when stdby=0. lcd_cnt (BLINK_BIT+1 bits) increments on tick and wraps freely.
- Frame phase ph = lcd_cnt[FRAME_BIT+2:FRAME_BIT]; k = ph[1:0] is the active COM, pol = ph[2], pwm = lcd_cnt[PWM_BIT].
- Char map, registered with 1-tick latency:
  - 0x00-0x0F: hex glyphs 0-F, standard a..g.
  - 0x2D: g only.
  - 0x5F: d only.
  - All other codes: blank.
- Sequencer (advances on tick only):
  - S_ADDR: present char_codes[idx] to char map; go to S_CAPT.
  - S_CAPT: latch[idx] = {dp[idx], map_out}, forced to 0 if blink_en[idx] & ~lcd_cnt[BLINK_BIT]. If idx == NUM_DIGITS-1, then idx=0 and refresh_done=1 for that clk_in cycle; else idx+1. Go to S_ADDR.
- Each digit is refreshed every 2*NUM_DIGITS ticks. A code change becomes visible within 2*NUM_DIGITS+1 ticks.
- Pin map, digit d:
  - seg[2d] carries {a,f,e,d} on COM0..3.
  - seg[2d+1] carries {b,g,c,dp} on COM0..3.
- Drive registers update on tick:
  - com[k] = ~pol; com[j != k] = pwm.
  - seg pin = pol if its segment for COM k is lit, else ~pol.
- Net DC per pixel is 0 over the 8-phase frame.
- lcd_com/lcd_seg = Z whenever stdby=1. Internal state is held, and driving resumes from the held state when stdby falls.
- rst mid-refresh aborts the scan; the display is blank until the next refresh.
- Inputs are sampled only in S_ADDR/S_CAPT on tick; changes at other times have no effect.

Test Plan (NUM_DIGITS=4, CLK_DIV_W=2, PWM_BIT=0, FRAME_BIT=2, BLINK_BIT=8):
- Reset then release → lcd_com=0, lcd_seg=0, refresh_done=0 until the first tick (clk_in cycle 4). First refresh_done fires after 8 ticks = 32 clk_in cycles.
- char_codes=0x03020100, dp=0, blink=0, after 1 refresh:
  - Digit0 "0": COM3 phase (ph=3), pol=0 → seg[0]=0 (d lit), seg[1]=1 (dp off), com[3]=1.
  - Other COMs toggle with pwm.
- char_codes digit2=0x41 (unmapped) → digit2 pins equal ~pol in every phase. Codes 0x2D/0x5F light only g/d respectively.
- blink_en=4'b0001, code 0x08 → digit0 latched blank while lcd_cnt[8]=0 and all segments lit while =1. Other digits are unaffected.
- stdby=1 mid-scan → outputs Z next cycle, lcd_cnt/idx frozen. stdby=0 → scan resumes at the same idx; refresh_done period is unchanged.
- Assert rst during S_CAPT of digit2 → all latches and outputs 0 asynchronously. After release, idx=0 and the next refresh_done is 32 clk_in cycles later.

Source files
------------

// File: rtl/lcd_scan_driver.sv
// N-digit, 4-COM multiplexed segment-LCD driver with 1/4 duty DC-balanced drive.
// Round-robin sequencer decodes character codes into per-digit segment latches.
module lcd_scan_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_DIV_W  = 2,
  parameter int unsigned PWM_BIT    = 2,
  parameter int unsigned FRAME_BIT  = 12,
  parameter int unsigned BLINK_BIT  = 20
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    stdby,
  input  logic [8*NUM_DIGITS-1:0] char_codes,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [3:0]              lcd_com,
  output logic [2*NUM_DIGITS-1:0] lcd_seg,
  output logic                    refresh_done
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = BLINK_BIT + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {S_ADDR, S_CAPT} state_t;

  logic [CLK_DIV_W-1:0]    prescaler;
  logic [CNT_W-1:0]        lcd_cnt;
  logic                    tick;
  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic [6:0]              map_out;
  logic [7:0]              seg_lat [NUM_DIGITS];
  logic [3:0]              com_q, com_nxt;
  logic [2*NUM_DIGITS-1:0] seg_q, seg_nxt;
  logic [1:0]              k;
  logic                    pol, pwm;

  assign tick = (&prescaler) & ~stdby;
  assign k    = lcd_cnt[FRAME_BIT +: 2];
  assign pol  = lcd_cnt[FRAME_BIT + 2];
  assign pwm  = lcd_cnt[PWM_BIT];

  // Segment bits are {g,f,e,d,c,b,a}
  function automatic logic [6:0] glyph(input logic [7:0] code);
    case (code)
      8'h00: glyph = 7'h3F;  8'h01: glyph = 7'h06;
      8'h02: glyph = 7'h5B;  8'h03: glyph = 7'h4F;
      8'h04: glyph = 7'h66;  8'h05: glyph = 7'h6D;
      8'h06: glyph = 7'h7D;  8'h07: glyph = 7'h07;
      8'h08: glyph = 7'h7F;  8'h09: glyph = 7'h6F;
      8'h0A: glyph = 7'h77;  8'h0B: glyph = 7'h7C;
      8'h0C: glyph = 7'h39;  8'h0D: glyph = 7'h5E;
      8'h0E: glyph = 7'h79;  8'h0F: glyph = 7'h71;
      8'h2D: glyph = 7'h40;
      8'h5F: glyph = 7'h08;
      default: glyph = 7'h00;
    endcase
  endfunction

  // Latch is {dp,g,f,e,d,c,b,a}; even pin = {a,f,e,d}, odd pin = {b,g,c,dp} on COM0..3
  function automatic logic pin_lit(input logic [7:0] lat, input logic [1:0] com, input logic odd);
    case (com)
      2'd0:    pin_lit = odd ? lat[1] : lat[0];
      2'd1:    pin_lit = odd ? lat[6] : lat[5];
      2'd2:    pin_lit = odd ? lat[2] : lat[4];
      default: pin_lit = odd ? lat[7] : lat[3];
    endcase
  endfunction

  // Prescaler and free-running frame/blink counter, both frozen in standby
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      lcd_cnt   <= '0;
    end else if (!stdby) begin
      prescaler <= prescaler + CLK_DIV_W'(1);
      if (tick) lcd_cnt <= lcd_cnt + CNT_W'(1);
    end
  end

  // Address/capture sequencer walking the digits round-robin
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state        <= S_ADDR;
      idx          <= '0;
      map_out      <= '0;
      refresh_done <= 1'b0;
      for (int d = 0; d < int'(NUM_DIGITS); d++) seg_lat[d] <= '0;
    end else begin
      refresh_done <= 1'b0;
      if (tick) begin
        case (state)
          S_ADDR: begin
            map_out <= glyph(char_codes[{idx, 3'b000} +: 8]);
            state   <= S_CAPT;
          end
          default: begin
            seg_lat[idx] <= (blink_en[idx] & ~lcd_cnt[BLINK_BIT]) ? 8'h00 : {dp[idx], map_out};
            if (idx == LAST_IDX) begin
              idx          <= '0;
              refresh_done <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
            state <= S_ADDR;
          end
        endcase
      end
    end
  end

  always_comb begin
    com_nxt    = {4{pwm}};
    com_nxt[k] = ~pol;
    seg_nxt    = '0;
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      seg_nxt[2*d]   = pol ~^ pin_lit(seg_lat[d], k, 1'b0);
      seg_nxt[2*d+1] = pol ~^ pin_lit(seg_lat[d], k, 1'b1);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      com_q <= '0;
      seg_q <= '0;
    end else if (tick) begin
      com_q <= com_nxt;
      seg_q <= seg_nxt;
    end
  end

  assign lcd_com = stdby ? {4{1'bz}} : com_q;
  assign lcd_seg = stdby ? {(2*NUM_DIGITS){1'bz}} : seg_q;

endmodule

// File: tb/tb_lcd_scan_driver.sv
// Scoreboard bench for lcd_scan_driver: a segment-letter reference model predicts
// COM/SEG pads and refresh_done each cycle; a negedge monitor compares.
module tb_lcd_scan_driver;

  localparam int ND   = 4;
  localparam int CDW  = 2;
  localparam int PWMB = 0;
  localparam int FRB  = 2;
  localparam int BLB  = 8;

  logic          clk_in = 1'b0;
  logic          rst;
  logic          stdby;
  logic [8*ND-1:0] char_codes;
  logic [ND-1:0] dp;
  logic [ND-1:0] blink_en;
  wire  [3:0]    lcd_com;
  wire  [2*ND-1:0] lcd_seg;
  wire           refresh_done;

  always #5 clk_in = ~clk_in;

  lcd_scan_driver #(
    .NUM_DIGITS(ND), .CLK_DIV_W(CDW), .PWM_BIT(PWMB), .FRAME_BIT(FRB), .BLINK_BIT(BLB)
  ) dut (
    .clk_in(clk_in), .rst(rst), .stdby(stdby), .char_codes(char_codes), .dp(dp),
    .blink_en(blink_en), .lcd_com(lcd_com), .lcd_seg(lcd_seg), .refresh_done(refresh_done)
  );

  typedef struct packed {
    logic          z;
    logic [3:0]    com;
    logic [2*ND-1:0] seg;
    logic          rd;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: lit segments held as letter strings, 'p' = decimal point
  string glyphs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
  string even_pin = "afed";
  string odd_pin  = "bgcp";
  int    m_pre, m_cnt, m_step;
  string m_lat [ND];
  string m_map;
  bit    m_rd;
  bit [3:0] m_com;
  bit [2*ND-1:0] m_seg;

  function automatic string glyph_str(bit [7:0] c);
    if (c < 8'd16) return glyphs[c];
    if (c == 8'h2D) return "g";
    if (c == 8'h5F) return "d";
    return "";
  endfunction

  function automatic bit lit(string s, byte ch);
    for (int i = 0; i < s.len(); i++) if (s[i] == ch) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_pre = 0; m_cnt = 0; m_step = 0; m_map = ""; m_rd = 0; m_com = '0; m_seg = '0;
    for (int d = 0; d < ND; d++) m_lat[d] = "";
  endtask

  // Advance the model by one clk_in edge using the inputs present before the edge
  task automatic model_step();
    int ph, k, idx;
    bit pol, pwm, tick, blank;
    m_rd = 0;
    if (rst || stdby) return;
    tick  = (m_pre == (1 << CDW) - 1);
    m_pre = (m_pre + 1) % (1 << CDW);
    if (!tick) return;
    ph  = (m_cnt >> FRB) % 8;
    k   = ph % 4;
    pol = (ph >= 4);
    pwm = ((m_cnt >> PWMB) % 2) == 1;
    for (int j = 0; j < 4; j++) m_com[j] = (j == k) ? !pol : pwm;
    for (int d = 0; d < ND; d++) begin
      m_seg[2*d]   = lit(m_lat[d], even_pin[k]) ? pol : !pol;
      m_seg[2*d+1] = lit(m_lat[d], odd_pin[k])  ? pol : !pol;
    end
    idx = m_step / 2;
    if (m_step % 2 == 0) begin
      m_map = glyph_str(char_codes[8*idx +: 8]);
    end else begin
      blank = blink_en[idx] && (((m_cnt >> BLB) % 2) == 0);
      m_lat[idx] = blank ? "" : (dp[idx] ? {m_map, "p"} : m_map);
      if (idx == ND - 1) m_rd = 1;
    end
    m_step = (m_step + 1) % (2 * ND);
    m_cnt  = (m_cnt + 1) % (1 << (BLB + 1));
  endtask

  task automatic push_expected();
    exp_t e;
    e.z = stdby; e.com = m_com; e.seg = m_seg; e.rd = m_rd;
    q.push_back(e);
  endtask

  task automatic run(int n);
    repeat (n) begin
      push_expected();
      @(posedge clk_in); #1;
      model_step();
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.z) begin
          chk("lcd_com_z", 32'(lcd_com === 4'bzzzz), 32'd1);
          chk("lcd_seg_z", 32'(lcd_seg === {(2*ND){1'bz}}), 32'd1);
        end else begin
          chk("lcd_com", 32'(lcd_com), 32'(e.com));
          chk("lcd_seg", 32'(lcd_seg), 32'(e.seg));
        end
        chk("refresh_done", 32'(refresh_done), 32'(e.rd));
      end
    end
  end

  function automatic logic [8*ND-1:0] rand_codes();
    logic [8*ND-1:0] c;
    for (int d = 0; d < ND; d++) begin
      case ($urandom_range(0, 3))
        0:       c[8*d +: 8] = 8'($urandom_range(0, 15));
        1:       c[8*d +: 8] = 8'h2D;
        2:       c[8*d +: 8] = 8'h5F;
        default: c[8*d +: 8] = 8'($urandom);
      endcase
    end
    return c;
  endfunction

  initial begin
    rst = 1'b1; stdby = 1'b0; char_codes = 32'h03020100; dp = '0; blink_en = '0;
    @(posedge clk_in); #1;
    model_reset();
    run(3);
    rst = 1'b0;
    run(200);
    // Unmapped code on digit2, dash and underscore on digits 1 and 3
    char_codes = 32'h5F412D00; dp = 4'b0010;
    run(200);
    char_codes = 32'h03020108; dp = '0; blink_en = 4'b0001;
    run(1200);
    stdby = 1'b1;
    run(37);
    stdby = 1'b0;
    run(150);
    repeat (25) begin
      char_codes = rand_codes();
      dp         = ND'($urandom);
      blink_en   = ND'($urandom);
      stdby      = ($urandom_range(0, 4) == 0);
      run($urandom_range(20, 200));
    end
    // Abort the scan while digit2 is being captured
    stdby = 1'b0; blink_en = '0; char_codes = 32'h0F0E0D0C; dp = 4'b1111;
    for (int i = 0; i < 200 && !(m_step == 5 && m_pre == 1); i++) run(1);
    rst = 1'b1;
    model_reset();
    run(3);
    rst = 1'b0;
    run(150);
    @(negedge clk_in); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
